// File: rtl/alu_pkg.sv
// Purpose : shared ALU instruction codes (also used by decode-stage ALU control),
//           FSM state type and a small opcode-classification helper.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRA = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_XOR = 4'd13;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_execute_unit_if.sv
// Purpose : operation-in / result-out handshake bundle of the execute-stage ALU.
// Latency : n/a (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; master = ID/EX side + EX/MEM side, slave = ALU.
interface alu_execute_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_instruction_e;
    logic [WIDTH-1:0] src_a_e;
    logic [WIDTH-1:0] src_b_e;
    logic [4:0]       shamt_e;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result_m;
    logic             zero_m;
    logic             illegal_m;

    modport master (
        output in_valid, alu_instruction_e, src_a_e, src_b_e, shamt_e, out_ready,
        input  in_ready, out_valid, alu_result_m, zero_m, illegal_m
    );

    modport slave (
        input  in_valid, alu_instruction_e, src_a_e, src_b_e, shamt_e, out_ready,
        output in_ready, out_valid, alu_result_m, zero_m, illegal_m
    );
endinterface

// File: rtl/alu_shift_iter.sv
// Purpose : 1-bit-per-cycle shifter (working register, down-counter, done/stall FSM).
// Latency : shamt cycles after start_i to done_o.
// Backpressure: final step stalls (holds register and counter) while out_free_i is low.
// Ports: clk/rst; start_i/code_i/operand_i/shamt_i load a job; out_free_i = result
//        register can be written; busy_o = SHIFT state; done_o/result_o = final value.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       code_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [4:0]       shamt_i,
    input  logic             out_free_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_step;

    // One-bit step of the latched shift kind.
    always_comb begin
        work_step = work_q;
        case (op_q)
            ALU_SLL: work_step = {work_q[WIDTH-2:0], 1'b0};
            ALU_SRL: work_step = {1'b0, work_q[WIDTH-1:1]};
            ALU_SRA: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_step = work_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    work_d  = operand_i;
                    cnt_d   = shamt_i;
                    op_d    = code_i;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != 5'd1) begin
                    work_d = work_step;
                    cnt_d  = cnt_q - 5'd1;
                end else if (out_free_i) begin
                    // Last bit is applied on the write edge itself.
                    work_d  = work_step;
                    cnt_d   = 5'd0;
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
                // else: result register still occupied, hold everything.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o   = (state_q == ST_SHIFT);
    assign result_o = work_step;

endmodule

// File: rtl/alu_execute_unit.sv
// Purpose : MIPS execute-stage ALU with registered result, zero and illegal flags.
// Latency : 1 cycle; shifts take 1 + shamt cycles when ALU_ITER_SHIFT_EN is defined.
// Backpressure: in_ready drops while the result register is full and not draining,
//               and for the whole iterative shift.
// Ports: clk/rst (async, active-high); bus = alu_execute_unit_if.slave.
// Config macro: ALU_ITER_SHIFT_EN (defined -> iterative shifter, undefined -> barrel shifter).
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_execute_unit_if.slave    bus
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             out_free;
    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wr_res;
    logic             wr_ill;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    // Single-cycle datapath; unsupported codes give 0 and raise illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.alu_instruction_e)
            ALU_AND: alu_res = bus.src_a_e & bus.src_b_e;
            ALU_OR:  alu_res = bus.src_a_e | bus.src_b_e;
            ALU_ADD: alu_res = bus.src_a_e + bus.src_b_e;
            ALU_SUB: alu_res = bus.src_a_e - bus.src_b_e;
            ALU_NOR: alu_res = ~(bus.src_a_e | bus.src_b_e);
            ALU_XOR: alu_res = bus.src_a_e ^ bus.src_b_e;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.src_a_e) < $signed(bus.src_b_e))};
            ALU_LUI: alu_res = {bus.src_b_e[15:0], {(WIDTH-16){1'b0}}};
`ifdef ALU_ITER_SHIFT_EN
            // Direct path only carries shifts with shamt 0.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.src_b_e;
`else
            ALU_SLL: alu_res = bus.src_b_e << bus.shamt_e;
            ALU_SRL: alu_res = bus.src_b_e >> bus.shamt_e;
            ALU_SRA: alu_res = $signed(bus.src_b_e) >>> bus.shamt_e;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign out_free = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

`ifdef ALU_ITER_SHIFT_EN
    logic             start_iter;
    logic             iter_busy;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;

    assign start_iter = accept && is_shift_op(bus.alu_instruction_e) && (bus.shamt_e != 5'd0);

    alu_shift_iter #(.WIDTH(WIDTH)) u_shift_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_iter),
        .code_i     (bus.alu_instruction_e),
        .operand_i  (bus.src_b_e),
        .shamt_i    (bus.shamt_e),
        .out_free_i (out_free),
        .busy_o     (iter_busy),
        .done_o     (iter_done),
        .result_o   (iter_res)
    );

    assign bus.in_ready = !iter_busy && out_free;
    // accept and iter_done never coincide: accept needs the shifter idle.
    assign wr_en  = (accept && !start_iter) || iter_done;
    assign wr_res = iter_done ? iter_res : alu_res;
    assign wr_ill = iter_done ? 1'b0 : alu_ill;
`else
    assign bus.in_ready = out_free;
    assign wr_en  = accept;
    assign wr_res = alu_res;
    assign wr_ill = alu_ill;
`endif

    // A write wins over a same-edge drain, so out_valid stays high with new data.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        if (wr_en) begin
            out_valid_d = 1'b1;
            result_d    = wr_res;
            zero_d      = (wr_res == '0);
            illegal_d   = wr_ill;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.alu_result_m = result_q;
    assign bus.zero_m       = zero_q;
    assign bus.illegal_m    = illegal_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
module tb_alu_execute_unit;

`ifdef ALU_ITER_SHIFT_EN
    localparam bit ITER = 1'b1;
`else
    localparam bit ITER = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    alu_execute_unit_if #(.WIDTH(32)) bus ();

    alu_execute_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op with out_ready high, wait (bounded) for the result, check it, drain it.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_res, input logic exp_ill);
        int cyc;
        int exp_lat;
        logic saw_rdy;
        exp_lat = (ITER && (code == 4'd4 || code == 4'd5 || code == 4'd8) && sh != 5'd0)
                  ? 1 + int'(sh) : 1;
        bus.out_ready         = 1'b1;
        bus.in_valid          = 1'b1;
        bus.alu_instruction_e = code;
        bus.src_a_e           = a;
        bus.src_b_e           = b;
        bus.shamt_e           = sh;
        chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        cyc     = 1;
        saw_rdy = 1'b0;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) saw_rdy = 1'b1;
            tick();
            cyc++;
        end
        chk({tag, "/out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "/result"}, bus.alu_result_m, exp_res);
        chk({tag, "/zero"}, {31'd0, bus.zero_m}, {31'd0, exp_res == 32'd0});
        chk({tag, "/illegal"}, {31'd0, bus.illegal_m}, {31'd0, exp_ill});
        chk({tag, "/latency"}, cyc, exp_lat);
        if (exp_lat > 1) chk({tag, "/busy_rdy"}, {31'd0, saw_rdy}, 32'd0);
        tick();
    endtask

    initial begin
        logic saw_valid;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_instruction_e = 4'd0;
        bus.src_a_e = 32'd0;
        bus.src_b_e = 32'd0;
        bus.shamt_e = 5'd0;
        tick();
        tick();
        chk("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst/result", bus.alu_result_m, 32'd0);
        chk("rst/zero", {31'd0, bus.zero_m}, 32'd0);
        chk("rst/illegal", {31'd0, bus.illegal_m}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst/in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Basic function
        run_op("add_ovf", 4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0);
        run_op("add_wrap",4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0);
        run_op("sub_eq",  4'd6,  32'd5,         32'd5,         5'd0, 32'h0000_0000, 1'b0);
        run_op("slt_neg", 4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0);
        run_op("slt_pos", 4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0);
        run_op("and",     4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0);
        run_op("or",      4'd1,  32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F, 1'b0);
        run_op("nor",     4'd12, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("xor",     4'd13, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h5555_5555, 1'b0);
        run_op("lui",     4'd9,  32'h0000_0000, 32'hDEAD_1234, 5'd0, 32'h1234_0000, 1'b0);
        run_op("sll4",    4'd4,  32'h0000_0000, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0);
        run_op("srl31",   4'd8,  32'h0000_0000, 32'h8000_0000, 5'd31,32'h0000_0001, 1'b0);
        run_op("sra31",   4'd5,  32'h0000_0000, 32'h8000_0000, 5'd31,32'hFFFF_FFFF, 1'b0);
        run_op("sra0",    4'd5,  32'h0000_0000, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0);
        run_op("ill15",   4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'h0000_0000, 1'b1);
        run_op("ill11",   4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b1);
        run_op("ill3",    4'd3,  32'h0000_0001, 32'h0000_0002, 5'd0, 32'h0000_0000, 1'b1);

        // Back-to-back throughput: two ADDs on consecutive edges
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_instruction_e = 4'd2;
        bus.src_a_e = 32'd100;
        bus.src_b_e = 32'd11;
        bus.shamt_e = 5'd0;
        tick();
        chk("b2b/res1", bus.alu_result_m, 32'd111);
        chk("b2b/in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.src_a_e = 32'd200;
        bus.src_b_e = 32'd22;
        tick();
        chk("b2b/res2", bus.alu_result_m, 32'd222);
        chk("b2b/valid2", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("b2b/drained", {31'd0, bus.out_valid}, 32'd0);

        // Back-pressure
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.src_a_e = 32'd1;
        bus.src_b_e = 32'd2;
        tick();
        chk("bp/res1", bus.alu_result_m, 32'd3);
        bus.src_a_e = 32'd10;
        bus.src_b_e = 32'd20;
        chk("bp/refused", {31'd0, bus.in_ready}, 32'd0);
        tick();
        tick();
        chk("bp/held_res", bus.alu_result_m, 32'd3);
        chk("bp/held_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("bp/still_refused", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp/ready_on_drain", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("bp/res2", bus.alu_result_m, 32'd30);
        chk("bp/vld2", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp/drained", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of an SLL by 10
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_instruction_e = 4'd4;
        bus.src_b_e = 32'h0000_0001;
        bus.shamt_e = 5'd10;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #2;
        chk("mrst/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst/result", bus.alu_result_m, 32'd0);
        chk("mrst/zero", {31'd0, bus.zero_m}, 32'd0);
        chk("mrst/illegal", {31'd0, bus.illegal_m}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst/in_ready", {31'd0, bus.in_ready}, 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.out_valid) saw_valid = 1'b1;
            tick();
        end
        chk("mrst/no_stale", {31'd0, saw_valid}, 32'd0);
        run_op("post_rst", 4'd2, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
